// File: rtl/restoring_divider_param.sv
// restoring_divider_param: multi-cycle restoring divider producing one quotient bit per clock.
// A nonzero-divisor operation completes WIDTH+1 cycles after the accepting edge; a zero
// divisor skips the iteration phase and completes on the very next edge.
// Optional feature: define RESTORING_DIV_SIGNED_EN to add the signed_op input and
// two's-complement division (magnitudes are divided, signs are fixed up in the final state).

module restoring_divider_param #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef RESTORING_DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned     CntW     = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;   // partial remainder A
    logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;   // captured divisor (magnitude in signed mode)
    logic             dbz_q, dbz_d;   // captured divisor-was-zero flag
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic             divisor_zero;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;

    assign divisor_zero = (divisor == '0);

`ifdef RESTORING_DIV_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;
    logic dvd_neg;
    logic dvs_neg;

    // Operand sign detection and magnitude extraction for signed requests
    always_comb begin
        dvd_neg = signed_op & dividend[WIDTH-1];
        dvs_neg = signed_op & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? ({WIDTH{1'b0}} - dividend) : dividend;
        dvs_mag = dvs_neg ? ({WIDTH{1'b0}} - divisor) : divisor;
    end

    // Sign correction of the unsigned magnitude result; most-negative / -1 wraps naturally
    always_comb begin
        quo_fixed = neg_quo_q ? ({WIDTH{1'b0}} - quo_q) : quo_q;
        rem_fixed = neg_rem_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    end

    // Sign flags captured alongside the operands
    always_comb begin
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (state_q == StIdle && start) begin
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
        end
    end

    // Sign flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    // Unsigned build: operands and results pass through unchanged
    always_comb begin
        dvd_mag   = dividend;
        dvs_mag   = divisor;
        quo_fixed = quo_q;
        rem_fixed = acc_q[WIDTH-1:0];
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a zero divisor bypasses the iteration phase
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = divisor_zero ? StFin : StRun;
                end
            end
            StRun: begin
                if (cnt_q == LastStep) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode: busy is registered from RUN, done from FIN
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
            end
            StRun: begin
                busy_d = 1'b1;
            end
            StFin: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // One restoring step: shift A:Q left, trial-subtract, keep result if non-negative.
    // A is always below the divisor, so the top bit of shifted is zero and trial's MSB
    // is a true sign bit.
    always_comb begin
        shifted = {acc_q, quo_q[WIDTH-1]};
        trial   = shifted - {2'b00, dvs_q};
    end

    // Datapath next-state: capture on acceptance, iterate in RUN, publish in FIN
    always_comb begin
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        quo_d         = quo_q;
        dvs_d         = dvs_q;
        dbz_d         = dbz_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d = '0;
                    acc_d = '0;
                    // On a zero divisor Q keeps the raw dividend to return as remainder
                    quo_d = divisor_zero ? dividend : dvd_mag;
                    dvs_d = dvs_mag;
                    dbz_d = divisor_zero;
                end
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
            end
            StFin: begin
                div_by_zero_d = dbz_q;
                if (dbz_q) begin
                    quotient_d  = '1;
                    remainder_d = quo_q;
                end else begin
                    quotient_d  = quo_fixed;
                    remainder_d = rem_fixed;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            acc_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            dbz_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            quo_q         <= quo_d;
            dvs_q         <= dvs_d;
            dbz_q         <= dbz_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule
